mem_arbiter_rr: RTL and testbench

MEM_ARBITER_RR -- requirements
Module: mem_arbiter_rr

---
 rtl/mem_arbiter_rr.sv | 136 +++++++++++++
 tb/tb_mem_arbiter_rr.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: round-robin arbiter that shares one memory port among
// CLIENT_CNT clients. A grant is held for a whole transaction and, when the
// client keeps request and lock high, for back-to-back transactions.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   client_requests/locks/wes   per-client request, lock and write enable
//   client_addrs_packed         per-client address, client i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   client_data_widths_packed   per-client access size (00=8, 01=16, 10=32)
//   client_data_outs_packed     per-client write data
//   client_readies              one-cycle completion pulse for the granted client
//   client_data_ins_packed      per-client registered read data
//   mem_*                       memory-side request, controls, data and completion
//   grant_idx                   current or last granted client
//   busy                        high whenever the FSM is not IDLE
module mem_arbiter_rr #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int CLIENT_CNT = 4,
  parameter int IDX_W      = $clog2(CLIENT_CNT)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [CLIENT_CNT-1:0]            client_requests,
  input  logic [CLIENT_CNT-1:0]            client_locks,
  input  logic [CLIENT_CNT*ADDR_WIDTH-1:0] client_addrs_packed,
  input  logic [CLIENT_CNT-1:0]            client_wes,
  input  logic [2*CLIENT_CNT-1:0]          client_data_widths_packed,
  input  logic [CLIENT_CNT*DATA_WIDTH-1:0] client_data_outs_packed,
  output logic [CLIENT_CNT-1:0]            client_readies,
  output logic [CLIENT_CNT*DATA_WIDTH-1:0] client_data_ins_packed,
  output logic                             mem_request,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic                             mem_we_out,
  output logic [1:0]                       mem_data_width,
  output logic [DATA_WIDTH-1:0]            mem_data_out,
  input  logic [DATA_WIDTH-1:0]            mem_data_in,
  input  logic                             mem_ready,
  output logic [IDX_W-1:0]                 grant_idx,
  output logic                             busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE, RELEASE} state_t;

  state_t                           state_q, state_d;
  logic [IDX_W-1:0]                 grant_q, grant_d;
  logic [IDX_W-1:0]                 last_q, last_d;
  logic [CLIENT_CNT*DATA_WIDTH-1:0] rdata_q, rdata_d;

  // Round-robin winner: first requester searching upward from last_q+1,
  // wrapping modulo CLIENT_CNT. last_q itself is checked last (offset
  // CLIENT_CNT), so a lone requester can win again.
  logic [IDX_W-1:0] rr_win;
  logic             rr_found;
  int               rr_j;

  always_comb begin
    rr_win   = grant_q;
    rr_found = 1'b0;
    rr_j     = 0;
    for (int k = 1; k <= CLIENT_CNT; k++) begin
      rr_j = (int'(last_q) + k) % CLIENT_CNT;
      if (!rr_found && client_requests[rr_j]) begin
        rr_found = 1'b1;
        rr_win   = IDX_W'(rr_j);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (|client_requests) begin
          state_d = ISSUE;
          grant_d = rr_win;
        end
      end
      ISSUE: begin
        // The granted request level is not looked at here: a transaction
        // that has been issued always runs to mem_ready.
        if (mem_ready) begin
          state_d = DONE;
          last_d  = grant_q;
          rdata_d[grant_q*DATA_WIDTH +: DATA_WIDTH] = mem_data_in;
        end
      end
      DONE: begin
        if (client_requests[grant_q] && client_locks[grant_q]) state_d = ISSUE;
        else                                                    state_d = RELEASE;
      end
      RELEASE: begin
        // Wait for the served client to drop its request so a stale level
        // is not mistaken for a new request.
        if (!client_requests[grant_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(CLIENT_CNT-1);
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      rdata_q <= rdata_d;
    end
  end

  // Status and strobes decode straight from the state register, so an
  // asynchronous reset clears them in the same cycle.
  always_comb begin
    client_readies = '0;
    if (state_q == DONE) client_readies[grant_q] = 1'b1;
  end

  assign mem_request            = (state_q == ISSUE);
  assign busy                   = (state_q != IDLE);
  assign grant_idx              = grant_q;
  assign client_data_ins_packed = rdata_q;

  // Memory controls always mirror the granted client, even when idle.
  assign mem_addr       = client_addrs_packed[grant_q*ADDR_WIDTH +: ADDR_WIDTH];
  assign mem_we_out     = client_wes[grant_q];
  assign mem_data_width = client_data_widths_packed[grant_q*2 +: 2];
  assign mem_data_out   = client_data_outs_packed[grant_q*DATA_WIDTH +: DATA_WIDTH];

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// tb_mem_arbiter_rr: directed bench for mem_arbiter_rr. Stimulus pushes the
// expected (client, read data) sequence into a queue; a monitor pops an entry
// on every ready pulse and compares pulse position and all data slots.
// The memory model answers mem_addr ^ 8'hE5 after lat+1 ISSUE cycles.
module tb_mem_arbiter_rr;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int CN = 4;
  localparam int IW = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [CN-1:0]    req = '0, lock = '0, we = '0;
  logic [CN*AW-1:0] addrs;
  logic [2*CN-1:0]  dws;
  logic [CN*DW-1:0] douts;
  logic [CN-1:0]    rdy;
  logic [CN*DW-1:0] dins;
  logic             mem_request, mem_we_out, mem_ready;
  logic [AW-1:0]    mem_addr;
  logic [1:0]       mem_data_width;
  logic [DW-1:0]    mem_data_out, mem_data_in;
  logic [IW-1:0]    grant_idx;
  logic             busy;

  logic          resp_rdy = 1'b0, stray_rdy = 1'b0;
  logic [DW-1:0] resp_data = '0, stray_data = '0;
  assign mem_ready   = resp_rdy | stray_rdy;
  assign mem_data_in = resp_rdy ? resp_data : stray_data;

  always #5 clk = ~clk;

  mem_arbiter_rr #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CLIENT_CNT(CN), .IDX_W(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .client_requests(req), .client_locks(lock),
    .client_addrs_packed(addrs), .client_wes(we),
    .client_data_widths_packed(dws), .client_data_outs_packed(douts),
    .client_readies(rdy), .client_data_ins_packed(dins),
    .mem_request(mem_request), .mem_addr(mem_addr), .mem_we_out(mem_we_out),
    .mem_data_width(mem_data_width), .mem_data_out(mem_data_out),
    .mem_data_in(mem_data_in), .mem_ready(mem_ready),
    .grant_idx(grant_idx), .busy(busy)
  );

  typedef struct { int c; logic [DW-1:0] d; } exp_t;
  exp_t q[$];
  exp_t mon_e;
  int errors = 0;
  int checks = 0;
  logic [DW-1:0] shadow [CN];
  // Hand-computed read data per client: addr ^ 8'hE5 for addrs 11,22,40,33.
  logic [DW-1:0] exp_data [CN];
  int lat = 2;
  int rsp_cnt = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, expv);
    end
  endfunction

  // Memory model
  always begin
    @(negedge clk);
    resp_rdy = 1'b0;
    if (rst_n && mem_request) begin
      if (rsp_cnt == lat) begin
        resp_rdy  = 1'b1;
        resp_data = mem_addr ^ 8'hE5;
        rsp_cnt   = 0;
      end else rsp_cnt++;
    end else rsp_cnt = 0;
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < CN; i++) shadow[i] = '0;
    end else if (rdy != '0) begin
      if (q.size() == 0) chk("unexpected_ready", 32'(rdy), 32'd0);
      else begin
        mon_e = q.pop_front();
        chk("ready_client", 32'(rdy), 32'(1 << mon_e.c));
        shadow[mon_e.c] = mon_e.d;
        for (int i = 0; i < CN; i++) chk("data_slot", 32'(dins[i*DW +: DW]), 32'(shadow[i]));
      end
    end
  end

  // Client model: on its ready pulse a client counts down; with lock it keeps
  // requesting, otherwise it drops and re-requests 3 cycles later.
  int rem [CN];
  int dly [CN];
  bit auto_en = 1'b0;

  task automatic tick();
    @(negedge clk);
    #1;
    if (auto_en) begin
      for (int i = 0; i < CN; i++) begin
        if (rdy[i]) begin
          rem[i]--;
          if (rem[i] <= 0) begin req[i] = 1'b0; lock[i] = 1'b0; end
          else if (!lock[i]) begin req[i] = 1'b0; dly[i] = 3; end
        end else if (dly[i] > 0) begin
          dly[i]--;
          if (dly[i] == 0) req[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic push(int c, int n);
    exp_t e;
    e.c = c;
    e.d = exp_data[c];
    for (int k = 0; k < n; k++) q.push_back(e);
  endtask

  task automatic wait_done(string name);
    int k;
    for (k = 0; k < 400; k++) begin
      tick();
      if (q.size() == 0 && !busy && req == '0) break;
    end
    checks++;
    if (k == 400) begin
      errors++;
      $display("FAIL %s_timeout: got %0d pending want 0", name, q.size());
      q.delete();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    exp_data[0] = 8'hF4; exp_data[1] = 8'hC7; exp_data[2] = 8'hA5; exp_data[3] = 8'hD6;
    addrs = {8'h33, 8'h40, 8'h22, 8'h11};
    dws   = {2'b10, 2'b01, 2'b00, 2'b01};
    douts = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    for (int i = 0; i < CN; i++) begin rem[i] = 0; dly[i] = 0; end

    // Reset state
    tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mem_request", 32'(mem_request), 0);
    chk("rst_readies", 32'(rdy), 0);
    chk("rst_grant", 32'(grant_idx), 0);
    chk("rst_data_ins", dins, 0);
    rst_n = 1'b1;
    tick();

    // Single read by client 2, memory answers on the 3rd ISSUE cycle
    push(2, 1);
    req[2] = 1'b1;
    tick();
    chk("t1_mem_request", 32'(mem_request), 1);
    chk("t1_mem_addr", 32'(mem_addr), 32'h40);
    chk("t1_grant", 32'(grant_idx), 2);
    chk("t1_we", 32'(mem_we_out), 0);
    chk("t1_width", 32'(mem_data_width), 32'b01);
    for (int k = 0; k < 20 && q.size() != 0; k++) tick();
    chk("t1_served", 32'(q.size()), 0);
    tick();
    chk("t1_release_busy", 32'(busy), 1);
    chk("t1_release_memreq", 32'(mem_request), 0);
    // Stray mem_ready while held in RELEASE
    stray_data = 8'h99; stray_rdy = 1'b1;
    tick();
    stray_rdy = 1'b0;
    chk("t1_stray_rel_busy", 32'(busy), 1);
    chk("t1_stray_rel_rdy", 32'(rdy), 0);
    chk("t1_stray_rel_slot", 32'(dins[2*DW +: DW]), 32'hA5);
    chk("t1_stray_rel_memreq", 32'(mem_request), 0);
    req[2] = 1'b0;
    tick();
    chk("t1_idle_busy", 32'(busy), 0);
    // Stray mem_ready in IDLE
    stray_data = 8'h77; stray_rdy = 1'b1;
    tick();
    stray_rdy = 1'b0;
    chk("t1_stray_idle_busy", 32'(busy), 0);
    chk("t1_stray_idle_slot", 32'(dins[2*DW +: DW]), 32'hA5);
    chk("t1_stray_idle_rdy", 32'(rdy), 0);

    // Wrap: last_grant=3 after reset, only client 3 requests, twice
    do_reset();
    auto_en = 1'b1;
    rem[3] = 2;
    push(3, 2);
    req[3] = 1'b1;
    wait_done("wrap");

    // Round robin over clients 0,1,3
    do_reset();
    rem[0] = 2; rem[1] = 2; rem[3] = 2;
    push(0, 1); push(1, 1); push(3, 1);
    push(0, 1); push(1, 1); push(3, 1);
    req = 4'b1011;
    wait_done("rr");

    // Locked client 1 for 3 transactions, client 0 waits
    do_reset();
    rem[1] = 3; rem[0] = 1;
    push(1, 3); push(0, 1);
    req[1] = 1'b1; lock[1] = 1'b1;
    tick();
    req[0] = 1'b1;
    chk("lock_grant", 32'(grant_idx), 1);
    wait_done("lock");

    // Reset in ISSUE, then 0/2 simultaneous request
    auto_en = 1'b0;
    lat = 4;
    req[1] = 1'b1;
    tick();
    tick();
    chk("t5_pre_memreq", 32'(mem_request), 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_memreq", 32'(mem_request), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_rdy", 32'(rdy), 0);
    chk("t5_rst_grant", 32'(grant_idx), 0);
    req = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    lat = 2;
    auto_en = 1'b1;
    rem[0] = 1; rem[2] = 1;
    push(0, 1); push(2, 1);
    req = 4'b0101;
    wait_done("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
